// File: rtl/cmp_pair_sequencer.sv
// Sequencer around a multi-cycle L/E/G comparator: takes one operand pair, pulses load,
// waits a fixed latency, captures the flags, hands the result out and tallies outcomes.
module cmp_pair_sequencer #(
  parameter int   WIDTH       = 32,
  parameter int   LATENCY     = 33,
  parameter int   CNT_W       = 16,
  parameter logic SERIAL_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic             cmp_mode,
  output logic             cmp_load,
  input  logic             cmp_l,
  input  logic             cmp_e,
  input  logic             cmp_g,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_l,
  output logic             out_e,
  output logic             out_g,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_l,
  output logic [CNT_W-1:0] cnt_e,
  output logic [CNT_W-1:0] cnt_g,
  output logic             busy
);
  localparam int WCW = $clog2(LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CAPT, S_OUT} state_t;

  state_t         state;
  logic [WCW-1:0] wcnt;
  logic           onehot;

  assign cmp_mode = SERIAL_MODE;
  assign onehot   = ({cmp_l, cmp_e, cmp_g} == 3'b100) ||
                    ({cmp_l, cmp_e, cmp_g} == 3'b010) ||
                    ({cmp_l, cmp_e, cmp_g} == 3'b001);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      cmp_load  <= 1'b0;
      cmp_a     <= '0;
      cmp_b     <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
      out_l     <= 1'b0;
      out_e     <= 1'b0;
      out_g     <= 1'b0;
      out_err   <= 1'b0;
      cnt_l     <= '0;
      cnt_e     <= '0;
      cnt_g     <= '0;
    end else begin
      cmp_load <= 1'b0;
      case (state)
        S_IDLE: if (in_valid && in_ready) begin
          cmp_a    <= in_a;
          cmp_b    <= in_b;
          cmp_load <= 1'b1;  // high for exactly the LOAD cycle
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          wcnt  <= WCW'(LATENCY - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == '0) state <= S_CAPT;
          else            wcnt  <= wcnt - WCW'(1);
        end
        S_CAPT: begin
          out_l     <= cmp_l;
          out_e     <= cmp_e;
          out_g     <= cmp_g;
          out_err   <= !onehot;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Clear beats a same-cycle capture increment; tallies stick at all-ones.
      if (cnt_clr) begin
        cnt_l <= '0;
        cnt_e <= '0;
        cnt_g <= '0;
      end else if (state == S_CAPT && onehot) begin
        if (cmp_l && cnt_l != '1) cnt_l <= cnt_l + CNT_W'(1);
        if (cmp_e && cnt_e != '1) cnt_e <= cnt_e + CNT_W'(1);
        if (cmp_g && cnt_g != '1) cnt_g <= cnt_g + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_cmp_pair_sequencer.sv
// Directed bench for cmp_pair_sequencer with a behavioural comparator driving L/E/G
// from the registered operands; counters are 2 bits wide so saturation is reachable.
module tb_cmp_pair_sequencer;
  localparam int LAT = 33;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [31:0]   in_a, in_b, cmp_a, cmp_b;
  logic          cmp_mode, cmp_load, cmp_l, cmp_e, cmp_g;
  logic          out_valid, out_ready, out_l, out_e, out_g, out_err;
  logic          cnt_clr, busy;
  logic [CW-1:0] cnt_l, cnt_e, cnt_g;
  logic          force_bad;
  int            n_tests = 0, n_fail = 0, load_cnt = 0;

  always #5 clk = ~clk;

  cmp_pair_sequencer #(.WIDTH(32), .LATENCY(LAT), .CNT_W(CW), .SERIAL_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_mode(cmp_mode), .cmp_load(cmp_load),
    .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g), .out_valid(out_valid), .out_ready(out_ready),
    .out_l(out_l), .out_e(out_e), .out_g(out_g), .out_err(out_err), .cnt_clr(cnt_clr),
    .cnt_l(cnt_l), .cnt_e(cnt_e), .cnt_g(cnt_g), .busy(busy));

  // Comparator model; force_bad drives an illegal L+E pattern.
  assign cmp_l = force_bad ? 1'b1 : (cmp_a < cmp_b);
  assign cmp_e = force_bad ? 1'b1 : (cmp_a == cmp_b);
  assign cmp_g = force_bad ? 1'b0 : (cmp_a > cmp_b);

  always @(posedge clk) if (cmp_load) load_cnt++;

  task automatic start_pair(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_in_ready got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_a = 32'hDEAD_BEEF; in_b = 32'h0;
  endtask

  // Called on the negedge right after the accepting edge; returns edges until out_valid.
  task automatic wait_result(output int k);
    k = 0;
    while (out_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
  endtask

  task automatic finish_pair();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL release got v=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || cmp_load !== 1'b0 || cmp_mode !== 1'b1 ||
        cmp_a !== 32'h0 || cmp_b !== 32'h0 || {out_l, out_e, out_g, out_err} !== 4'b0 ||
        {cnt_l, cnt_e, cnt_g} !== 6'b0) begin
      n_fail++; $display("FAIL reset_state rdy=%b v=%b busy=%b load=%b mode=%b a=%h b=%h leg=%b cnt=%b",
        in_ready, out_valid, busy, cmp_load, cmp_mode, cmp_a, cmp_b, {out_l, out_e, out_g, out_err}, {cnt_l, cnt_e, cnt_g});
    end
  endtask

  task automatic test_greater();
    int k, l0;
    l0 = load_cnt;
    start_pair(32'h9292B292, 32'h92929292);
    n_tests++; if (busy !== 1'b1 || in_ready !== 1'b0 || cmp_a !== 32'h9292B292 || cmp_b !== 32'h92929292) begin
      n_fail++; $display("FAIL g_capture busy=%b rdy=%b a=%h b=%h", busy, in_ready, cmp_a, cmp_b); end
    wait_result(k);
    n_tests++; if (k != LAT + 2) begin n_fail++; $display("FAIL g_latency got %0d want %0d", k, LAT + 2); end
    n_tests++; if ({out_l, out_e, out_g, out_err} !== 4'b0010) begin
      n_fail++; $display("FAIL g_flags got %b want 0010", {out_l, out_e, out_g, out_err}); end
    n_tests++; if (cnt_g !== 2'd1 || cnt_l !== 2'd0 || cnt_e !== 2'd0) begin
      n_fail++; $display("FAIL g_counts got l=%0d e=%0d g=%0d want 0 0 1", cnt_l, cnt_e, cnt_g); end
    n_tests++; if (load_cnt - l0 != 1) begin n_fail++; $display("FAIL g_loads got %0d want 1", load_cnt - l0); end
    finish_pair();
  endtask

  task automatic test_equal_less();
    int k, l0;
    l0 = load_cnt;
    start_pair(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_result(k);
    n_tests++; if ({out_l, out_e, out_g, out_err} !== 4'b0100 || cnt_e !== 2'd1) begin
      n_fail++; $display("FAIL e_result got %b cnt_e=%0d want 0100 1", {out_l, out_e, out_g, out_err}, cnt_e); end
    finish_pair();
    start_pair(32'h0, 32'h1);
    wait_result(k);
    n_tests++; if ({out_l, out_e, out_g, out_err} !== 4'b1000 || cnt_l !== 2'd1 || cnt_g !== 2'd1) begin
      n_fail++; $display("FAIL l_result got %b cnt_l=%0d cnt_g=%0d want 1000 1 1", {out_l, out_e, out_g, out_err}, cnt_l, cnt_g); end
    finish_pair();
    n_tests++; if (load_cnt - l0 != 2) begin n_fail++; $display("FAIL el_loads got %0d want 2", load_cnt - l0); end
  endtask

  task automatic test_backpressure();
    int k, l0, bad;
    start_pair(32'd5, 32'd3);
    wait_result(k);
    l0 = load_cnt; bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in_a = 32'd100 + i; in_b = 32'd0;
      @(negedge clk);
      if (out_valid !== 1'b1 || {out_l, out_e, out_g, out_err} !== 4'b0010 || in_ready !== 1'b0 ||
          cmp_a !== 32'd5 || busy !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    n_tests++; if (cnt_g !== 2'd2) begin n_fail++; $display("FAIL bp_count got %0d want 2", cnt_g); end
    finish_pair();
    repeat (3) @(negedge clk);
    n_tests++; if (load_cnt != l0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_ignored loads=%0d busy=%b want 0 0", load_cnt - l0, busy); end
  endtask

  task automatic test_error();
    int k;
    force_bad = 1'b1;
    start_pair(32'd7, 32'd7);
    wait_result(k);
    n_tests++; if ({out_l, out_e, out_g, out_err} !== 4'b1101) begin
      n_fail++; $display("FAIL err_flags got %b want 1101", {out_l, out_e, out_g, out_err}); end
    n_tests++; if (cnt_l !== 2'd1 || cnt_e !== 2'd1 || cnt_g !== 2'd2) begin
      n_fail++; $display("FAIL err_counts got %0d %0d %0d want 1 1 2", cnt_l, cnt_e, cnt_g); end
    finish_pair();
    force_bad = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, seen;
    start_pair(32'd9, 32'd4);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || cmp_a !== 32'h0 ||
                   {cnt_l, cnt_e, cnt_g} !== 6'b0 || {out_l, out_e, out_g, out_err} !== 4'b0) begin
      n_fail++; $display("FAIL midrst_state rdy=%b v=%b busy=%b a=%h cnt=%b", in_ready, out_valid, busy, cmp_a, {cnt_l, cnt_e, cnt_g}); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
    n_tests++; if (seen != 0 || cnt_g !== 2'd0) begin n_fail++; $display("FAIL midrst_noresult got %0d valid cycles want 0", seen); end
    start_pair(32'd1, 32'd2);
    wait_result(k);
    n_tests++; if (k != LAT + 2 || {out_l, out_e, out_g, out_err} !== 4'b1000 || cnt_l !== 2'd1) begin
      n_fail++; $display("FAIL midrst_next got k=%0d flags=%b cnt_l=%0d want %0d 1000 1", k, {out_l, out_e, out_g, out_err}, cnt_l, LAT + 2); end
    finish_pair();
  endtask

  task automatic test_saturation();
    int k;
    logic [CW-1:0] exp_g;
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    n_tests++; if ({cnt_l, cnt_e, cnt_g} !== 6'b0) begin n_fail++; $display("FAIL clr got %b want 0", {cnt_l, cnt_e, cnt_g}); end
    for (int i = 1; i <= 5; i++) begin
      exp_g = (i >= 3) ? 2'd3 : 2'(i);
      start_pair(32'd50 + i, 32'd10);
      wait_result(k);
      n_tests++; if (cnt_g !== exp_g) begin n_fail++; $display("FAIL sat_%0d got %0d want %0d", i, cnt_g, exp_g); end
      finish_pair();
    end
    // Sixth G result: assert clear so it lands on the capture edge (LAT+2 after accept).
    start_pair(32'd90, 32'd10);
    repeat (LAT + 1) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || cnt_g !== 2'd3) begin
      n_fail++; $display("FAIL preclr got v=%b cnt_g=%0d want 0 3", out_valid, cnt_g); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_g !== 1'b1 || cnt_g !== 2'd0) begin
      n_fail++; $display("FAIL clr_wins got v=%b g=%b cnt_g=%0d want 1 1 0", out_valid, out_g, cnt_g); end
    finish_pair();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; cnt_clr = 1'b0; force_bad = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_greater();
    test_equal_less();
    test_backpressure();
    test_error();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
